// File: rtl/instr_assembler.sv
// instr_assembler
//   Packs opcode, register fields, funct bits and a 32-bit immediate into a
//   RISC-V instruction word. The boot/test loader uses it to stream encoded
//   words into instruction memory. Each accepted request is range/alignment
//   checked. Legal words are presented with the byte address they belong at.
//
//   Optional feature: define ASM_RTYPE_EN to accept R-type (op 0110011).
//   Without it, R-type requests are rejected as unsupported.
//
// Parameters
//   ADDR_W     width of the byte-address counter
//   BASE_ADDR  byte address of the first emitted word (multiple of 4)
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   in_valid_i/ready_o request handshake
//   in_op_i .. in_imm_i fields of the request, latched on acceptance
//   out_valid_i/ready  word handshake; out_instr_o/out_addr_o hold while valid
//   addr_clr_i         reload the address counter to BASE_ADDR (any state)
//   err_o              one-cycle pulse on a rejected request
//   err_code_o         01 unsupported op, 10 imm range, 11 branch misaligned
//   word_cnt_o         words handed off, saturating at 0xFFFF
module instr_assembler #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [6:0]        in_op_i,
  input  logic [4:0]        in_rd_i,
  input  logic [4:0]        in_rs1_i,
  input  logic [4:0]        in_rs2_i,
  input  logic [2:0]        in_funct3_i,
  input  logic [6:0]        in_funct7_i,
  input  logic [31:0]       in_imm_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [31:0]       out_instr_o,
  output logic [ADDR_W-1:0] out_addr_o,
  input  logic              addr_clr_i,
  output logic              err_o,
  output logic [1:0]        err_code_o,
  output logic [15:0]       word_cnt_o
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;

  typedef enum logic [1:0] {IDLE, CHECK, OUT} state_e;

  state_e            state_q;
  logic [6:0]        op_q;
  logic [4:0]        rd_q, rs1_q, rs2_q;
  logic [2:0]        funct3_q;
  logic [6:0]        funct7_q;
  logic [31:0]       imm_q;
  logic              in_ready_q, out_valid_q, err_q;
  logic [31:0]       out_instr_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [1:0]        err_code_q;
  logic [15:0]       word_cnt_q;

  logic [31:0]       enc_word;
  logic [1:0]        enc_code;
  logic              fits12, fits13;
  logic [ADDR_W-1:0] out_addr_d;
  logic [15:0]       word_cnt_d;

  // Sign-extension checks: the upper bits must all be copies of the sign bit.
  assign fits12 = (&imm_q[31:11]) | ~(|imm_q[31:11]);
  assign fits13 = (&imm_q[31:12]) | ~(|imm_q[31:12]);

  always_comb begin
    enc_word = '0;
    enc_code = 2'b01;
    case (op_q)
      OP_LOAD, OP_IMM: begin
        enc_word = {imm_q[11:0], rs1_q, funct3_q, rd_q, op_q};
        enc_code = fits12 ? 2'b00 : 2'b10;
      end
      OP_STORE: begin
        enc_word = {imm_q[11:5], rs2_q, rs1_q, funct3_q, imm_q[4:0], op_q};
        enc_code = fits12 ? 2'b00 : 2'b10;
      end
      OP_BRANCH: begin
        enc_word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, funct3_q,
                    imm_q[4:1], imm_q[11], op_q};
        // Misalignment takes priority over range.
        if (imm_q[0])     enc_code = 2'b11;
        else if (!fits13) enc_code = 2'b10;
        else              enc_code = 2'b00;
      end
      OP_RTYPE: begin
        // The word is formed either way; it is only registered when legal.
        enc_word = {funct7_q, rs2_q, rs1_q, funct3_q, rd_q, op_q};
`ifdef ASM_RTYPE_EN
        enc_code = 2'b00;
`else
        enc_code = 2'b01;
`endif
      end
      default: begin
        enc_word = '0;
        enc_code = 2'b01;
      end
    endcase
  end

  // Address wraps modulo 2^ADDR_W (to 0, not BASE); the counter saturates.
  assign out_addr_d = out_addr_q + ADDR_W'(4);
  assign word_cnt_d = (word_cnt_q == 16'hFFFF) ? word_cnt_q : word_cnt_q + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      funct3_q    <= '0;
      funct7_q    <= '0;
      imm_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      out_instr_q <= '0;
      out_addr_q  <= BASE;
      err_code_q  <= 2'b00;
      word_cnt_q  <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            op_q       <= in_op_i;
            rd_q       <= in_rd_i;
            rs1_q      <= in_rs1_i;
            rs2_q      <= in_rs2_i;
            funct3_q   <= in_funct3_i;
            funct7_q   <= in_funct7_i;
            imm_q      <= in_imm_i;
            in_ready_q <= 1'b0;
            state_q    <= CHECK;
          end
        end
        CHECK: begin
          if (enc_code == 2'b00) begin
            out_instr_q <= enc_word;
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end else begin
            err_q      <= 1'b1;
            err_code_q <= enc_code;
            in_ready_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        OUT: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            out_addr_q  <= out_addr_d;
            word_cnt_q  <= word_cnt_d;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
      // A clear overrides any advance made on the same edge.
      if (addr_clr_i) out_addr_q <= BASE;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_instr_o = out_instr_q;
  assign out_addr_o  = out_addr_q;
  assign err_o       = err_q;
  assign err_code_o  = err_code_q;
  assign word_cnt_o  = word_cnt_q;

endmodule
